// File: rtl/lsu_mem_bridge_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// bus FSM states and access-size decoding.
package lsu_mem_bridge_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } lsu_size_t;

    // Any encoding other than byte/half is handled as a full word.
    function automatic lsu_size_t accessSize(input logic [2:0] funct3);
        lsu_size_t size;
        case (funct3)
            LSU_B, LSU_BU: size = SIZE_B;
            LSU_H, LSU_HU: size = SIZE_H;
            default:       size = SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment helper: store lane steering, misalign detection and
// load data extraction/extension. Purely combinational.
module lsu_align
    import lsu_mem_bridge_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic        isStore,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdataLane,
    output logic        misaligned,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadAddrLo,
    input  logic [31:0] rawData,
    output logic [31:0] loadData
);

    lsu_size_t   reqSize;
    lsu_size_t   loadSize;
    logic [31:0] rawShifted;

    always_comb begin
        reqSize    = accessSize(funct3);
        misaligned = 1'b0;
        be         = 4'b1111;
        wdataLane  = '0;

        case (reqSize)
            SIZE_H:  misaligned = addrLo[0];
            SIZE_W:  misaligned = |addrLo;
            default: misaligned = 1'b0;
        endcase

        if (isStore) begin
            case (reqSize)
                SIZE_B:  be = 4'b0001 << addrLo;
                SIZE_H:  be = 4'b0011 << addrLo;
                default: be = 4'b1111;
            endcase
            wdataLane = wdata << {addrLo, 3'b000};
        end
    end

    // funct3[2] distinguishes the unsigned byte/half loads.
    always_comb begin
        loadSize   = accessSize(loadFunct3);
        rawShifted = rawData >> {loadAddrLo, 3'b000};
        loadData   = rawData;

        case (loadSize)
            SIZE_B:  loadData = loadFunct3[2] ? {24'b0, rawShifted[7:0]}
                                              : {{24{rawShifted[7]}}, rawShifted[7:0]};
            SIZE_H:  loadData = loadFunct3[2] ? {16'b0, rawShifted[15:0]}
                                              : {{16{rawShifted[15]}}, rawShifted[15:0]};
            default: loadData = rawData;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Memory-stage load/store unit: turns an M-stage access into a req/gnt/rvalid
// bus transaction, stalling the pipeline until the response (or timeout).
module lsu_mem_bridge
    import lsu_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_m,
    input  logic        is_store_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic        stall_m,
    output logic [31:0] rdata_m,
    output logic        misalign_m,
    output logic        err_m,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t      state;
    lsu_state_t      stateNext;
    logic [2:0]      funct3Q;
    logic [1:0]      addrLoQ;
    logic [31:0]     rawQ;
    logic            errQ;
    logic [TO_W-1:0] toCnt;

    logic [3:0]      alignBe;
    logic [31:0]     alignWdata;
    logic            misaligned;
    logic [31:0]     loadData;
    logic            acceptReq;

    lsu_align uAlign (
        .funct3     (funct3_m),
        .addrLo     (addr_m[1:0]),
        .isStore    (is_store_m),
        .wdata      (wdata_m),
        .be         (alignBe),
        .wdataLane  (alignWdata),
        .misaligned (misaligned),
        .loadFunct3 (funct3Q),
        .loadAddrLo (addrLoQ),
        .rawData    (rawQ),
        .loadData   (loadData)
    );

    assign acceptReq = req_valid_m && !misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Stall is raised combinationally in IDLE so the pipeline freezes on the
    // very cycle the access is first seen.
    always_comb begin
        stateNext  = state;
        bus_req    = 1'b0;
        stall_m    = 1'b0;
        misalign_m = 1'b0;
        err_m      = 1'b0;
        rdata_m    = '0;

        case (state)
            IDLE: begin
                stall_m    = acceptReq;
                misalign_m = rst_n && req_valid_m && misaligned;
                if (acceptReq) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall_m = 1'b1;
                if (bus_gnt) begin
                    stateNext = bus_rvalid ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_m = 1'b1;
                if (bus_rvalid || (toCnt == TO_LAST)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                err_m     = errQ;
                rdata_m   = loadData;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request attributes are latched on acceptance and held for the whole
    // transaction; stores never return data, so rawQ stays zero for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3Q   <= '0;
            addrLoQ   <= '0;
            rawQ      <= '0;
            errQ      <= 1'b0;
            toCnt     <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acceptReq) begin
                        funct3Q   <= funct3_m;
                        addrLoQ   <= addr_m[1:0];
                        bus_we    <= is_store_m;
                        bus_addr  <= {addr_m[31:2], 2'b00};
                        bus_be    <= alignBe;
                        bus_wdata <= alignWdata;
                        rawQ      <= '0;
                        errQ      <= 1'b0;
                        toCnt     <= '0;
                    end
                end
                REQ: begin
                    if (bus_gnt && bus_rvalid) begin
                        rawQ <= bus_we ? '0 : bus_rdata;
                        errQ <= bus_err;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        rawQ <= bus_we ? '0 : bus_rdata;
                        errQ <= bus_err;
                    end else if (toCnt == TO_LAST) begin
                        rawQ <= '0;
                        errQ <= 1'b1;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: directed accesses push expected bus
// requests and pipeline responses; a negedge monitor pops and compares them.
module tb_lsu_mem_bridge;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_m;
    logic        is_store_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic        stall_m;
    logic [31:0] rdata_m;
    logic        misalign_m;
    logic        err_m;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    typedef struct {
        logic        isMis;
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chkW;
    } busexp_t;

    resp_t   expQ[$];
    busexp_t busQ[$];
    int      compareCount = 0;
    int      failCount    = 0;
    int      eventCount   = 0;
    int      stallCnt     = 0;

    lsu_mem_bridge #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_m (req_valid_m),
        .is_store_m  (is_store_m),
        .funct3_m    (funct3_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .stall_m     (stall_m),
        .rdata_m     (rdata_m),
        .misalign_m  (misalign_m),
        .err_m       (err_m),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expectBus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic chkW);
        busexp_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.chkW = chkW;
        busQ.push_back(b);
    endtask

    task automatic expectResp(input logic isMis, input logic [31:0] rdata, input logic err, input int stall);
        resp_t r;
        r.isMis = isMis; r.rdata = rdata; r.err = err; r.stall = stall;
        expQ.push_back(r);
    endtask

    // Monitor: bus requests are checked every cycle they are raised (so they
    // must stay stable until grant); pipeline responses at DONE or misalign.
    always @(negedge clk) begin
        busexp_t b;
        resp_t   r;
        if (!rst_n) begin
            stallCnt = 0;
        end else begin
            if (bus_req) begin
                if (busQ.size() == 0) begin
                    compareCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected bus_req: got addr %h be %h expected no request", bus_addr, bus_be);
                end else begin
                    b = busQ[0];
                    checkOutput("bus_we", {31'b0, bus_we}, {31'b0, b.we});
                    checkOutput("bus_addr", bus_addr, b.addr);
                    checkOutput("bus_be", {28'b0, bus_be}, {28'b0, b.be});
                    if (b.chkW) checkOutput("bus_wdata", bus_wdata, b.wdata);
                    if (bus_gnt) void'(busQ.pop_front());
                end
            end
            if (misalign_m || (!stall_m && stallCnt > 0)) begin
                eventCount++;
                if (expQ.size() == 0) begin
                    compareCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected response: got misalign %b err %b rdata %h expected none",
                             misalign_m, err_m, rdata_m);
                end else begin
                    r = expQ.pop_front();
                    checkOutput("misalign_m", {31'b0, misalign_m}, {31'b0, r.isMis});
                    checkOutput("err_m", {31'b0, err_m}, {31'b0, r.err});
                    checkOutput("rdata_m", rdata_m, r.rdata);
                    checkOutput("stall_m", {31'b0, stall_m}, 32'd0);
                    checkOutput("stallCycles", stallCnt, r.stall);
                end
                stallCnt = 0;
            end else if (stall_m) begin
                stallCnt++;
            end
        end
    end

    // Drives one M-stage access; gntDly<0 means no bus phase, rvDly<0 means
    // the response never arrives, rvDly=0 means rvalid together with grant.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int gntDly, input int rvDly,
                                 input logic [31:0] rd, input logic berr);
        int startCnt;
        bit seen;
        startCnt    = eventCount;
        req_valid_m = 1'b1;
        is_store_m  = st;
        funct3_m    = f3;
        addr_m      = addr;
        wdata_m     = wd;
        @(posedge clk); #1;
        req_valid_m = 1'b0;
        if (gntDly >= 0) begin
            repeat (gntDly) begin @(posedge clk); #1; end
            bus_gnt = 1'b1;
            if (rvDly == 0) begin
                bus_rvalid = 1'b1; bus_rdata = rd; bus_err = berr;
            end
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
            if (rvDly > 0) begin
                repeat (rvDly - 1) begin @(posedge clk); #1; end
                bus_rvalid = 1'b1; bus_rdata = rd; bus_err = berr;
                @(posedge clk); #1;
                bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (eventCount != startCnt) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL responseTimeout: got no response for addr %h expected one within 40 cycles", addr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_m = 1'b0; is_store_m = 1'b0; funct3_m = 3'b000; addr_m = '0; wdata_m = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        #12;
        checkOutput("rst bus_req", {31'b0, bus_req}, 32'd0);
        checkOutput("rst bus_we", {31'b0, bus_we}, 32'd0);
        checkOutput("rst bus_addr", bus_addr, 32'd0);
        checkOutput("rst bus_be", {28'b0, bus_be}, 32'd0);
        checkOutput("rst bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst rdata_m", rdata_m, 32'd0);
        checkOutput("rst err_m", {31'b0, err_m}, 32'd0);
        checkOutput("rst misalign_m", {31'b0, misalign_m}, 32'd0);
        checkOutput("rst stall_m", {31'b0, stall_m}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] aligned stores and loads");
        expectBus(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1); expectResp(1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0);
        expectBus(1'b1, 32'h100, 4'b1000, 32'hA5000000, 1'b1); expectResp(1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 32'h0, 1'b0);
        expectBus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'hFFFFFF80, 1'b0, 3);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF0000, 1'b0);
        expectBus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'h00000080, 1'b0, 4);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 0, 2, 32'h80FF0000, 1'b0);
        expectBus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'hFFFF8001, 1'b0, 2);
        applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80011234, 1'b0);
        expectBus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'h00008001, 1'b0, 2);
        applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80011234, 1'b0);
        expectBus(1'b1, 32'h100, 4'b1100, 32'hBEEF0000, 1'b1); expectResp(1'b0, 32'h0, 1'b0, 4);
        applyStimulus(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 2, 0, 32'h0, 1'b0);

        $display("[TB] misaligned accesses");
        expectResp(1'b1, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, -1, -1, 32'h0, 1'b0);
        expectResp(1'b1, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, 3'b001, 32'h103, 32'h1234, -1, -1, 32'h0, 1'b0);
        expectResp(1'b1, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 3'b011, 32'h102, 32'h0, -1, -1, 32'h0, 1'b0);

        $display("[TB] grant hold-off with bus error, then timeout");
        expectBus(1'b0, 32'h204, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'h12345678, 1'b1, 8);
        applyStimulus(1'b0, 3'b010, 32'h204, 32'h0, 5, 1, 32'h12345678, 1'b1);
        expectBus(1'b0, 32'h300, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'h0, 1'b1, 2 + TIMEOUT);
        applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 0, -1, 32'h0, 1'b0);

        $display("[TB] reset in WAIT, stray bus responses");
        expectBus(1'b0, 32'h400, 4'b1111, 32'h0, 1'b0);
        req_valid_m = 1'b1; is_store_m = 1'b0; funct3_m = 3'b010; addr_m = 32'h400;
        @(posedge clk); #1;
        req_valid_m = 1'b0;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst bus_req", {31'b0, bus_req}, 32'd0);
        checkOutput("midrst stall_m", {31'b0, stall_m}, 32'd0);
        checkOutput("midrst err_m", {31'b0, err_m}, 32'd0);
        checkOutput("midrst bus_be", {28'b0, bus_be}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hFFFFFFFF; bus_err = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_gnt = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        @(posedge clk); #1;
        expectBus(1'b0, 32'h108, 4'b1111, 32'h0, 1'b0); expectResp(1'b0, 32'hCAFEF00D, 1'b0, 4);
        applyStimulus(1'b0, 3'b010, 32'h108, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pending responses", expQ.size(), 32'd0);
        checkOutput("pending bus requests", busQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
